// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with programmable thresholds,
// fill level, sticky error flags and standard/FWFT read modes.
module fifo_param #(
    parameter int DATA_W       = 128,
    parameter int DEPTH        = 16,
    parameter int ALM_FULL_TH  = 14,
    parameter int ALM_EMPTY_TH = 2,
    parameter int FWFT         = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wren,
    input  logic [DATA_W-1:0]          i_wrdata,
    input  logic                       i_rden,
    input  logic                       i_clr_err,
    output logic [DATA_W-1:0]          o_rddata,
    output logic                       o_rd_valid,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_alm_full,
    output logic                       o_alm_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic                       o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(ALM_FULL_TH);
    localparam logic [CW-1:0] AE_C   = CW'(ALM_EMPTY_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              alm_full_q, alm_full_d;
    logic              alm_empty_q, alm_empty_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              rd_ok, wr_ok;

    // Accept decisions, pointer/count update and flags precomputed
    // from the next count so every status output is a plain register.
    always_comb begin
        rd_ok    = i_rden && !empty_q;
        wr_ok    = i_wren && (!full_q || rd_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d      = (count_d == FULL_C);
        empty_d     = (count_d == '0);
        alm_full_d  = (count_d >= AF_C);
        alm_empty_d = (count_d <= AE_C);
        // a new error event outranks a coincident clear
        ovf_d = (ovf_q && !i_clr_err) || (i_wren && !wr_ok);
        unf_d = (unf_q && !i_clr_err) || (i_rden && empty_q);
    end

    // Control state: pointers, fill level, status and error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            alm_full_q  <= 1'b0;
            alm_empty_q <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            alm_full_q  <= alm_full_d;
            alm_empty_q <= alm_empty_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= i_wrdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; zero while empty.
            assign o_rd_valid = !empty_q;
            assign o_rddata   = empty_q ? '0 : mem_q[rd_ptr_q];
        end else begin : g_std
            logic [DATA_W-1:0] rddata_q;
            logic              rd_valid_q;

            // Registered read port with one cycle of latency.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rddata_q   <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_ok;
                    if (rd_ok) rddata_q <= mem_q[rd_ptr_q];
                end
            end

            assign o_rd_valid = rd_valid_q;
            assign o_rddata   = rddata_q;
        end
    endgenerate

    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_alm_full  = alm_full_q;
    assign o_alm_empty = alm_empty_q;
    assign o_count     = count_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: table of single-cycle vectors
// on a standard-mode instance plus FWFT and reset sequences.
module tb_fifo_param;

    localparam int DW = 128;
    localparam int CW = 5;

    logic          clk, rst;
    logic          wren, rden, clr;
    logic [DW-1:0] wrdata;

    logic [DW-1:0] rddata, f_rddata;
    logic          rd_valid, f_rd_valid;
    logic          full, f_full, empty, f_empty;
    logic          afull, f_afull, aempty, f_aempty;
    logic [CW-1:0] count, f_count;
    logic          ovf, f_ovf, unf, f_unf;

    fifo_param #(.FWFT(0)) dut (
        .clk(clk), .rst(rst),
        .i_wren(wren), .i_wrdata(wrdata),
        .i_rden(rden), .i_clr_err(clr),
        .o_rddata(rddata), .o_rd_valid(rd_valid),
        .o_full(full), .o_empty(empty),
        .o_alm_full(afull), .o_alm_empty(aempty),
        .o_count(count),
        .o_overflow(ovf), .o_underflow(unf)
    );

    fifo_param #(.FWFT(1)) dut_f (
        .clk(clk), .rst(rst),
        .i_wren(wren), .i_wrdata(wrdata),
        .i_rden(rden), .i_clr_err(clr),
        .o_rddata(f_rddata), .o_rd_valid(f_rd_valid),
        .o_full(f_full), .o_empty(f_empty),
        .o_alm_full(f_afull), .o_alm_empty(f_aempty),
        .o_count(f_count),
        .o_overflow(f_ovf), .o_underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [DW-1:0] wd;
        logic          re;
        logic          cl;
        int            cnt;
        logic          ovf;
        logic          unf;
        logic          vld;
        logic          chk;
        logic [DW-1:0] data;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic cmp(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [DW-1:0] wd,
                                input logic re, input logic cl,
                                input int cnt, input logic ov,
                                input logic un, input logic vl,
                                input logic ck, input logic [DW-1:0] d);
        vec_t v;
        v.we = we; v.wd = wd; v.re = re; v.cl = cl;
        v.cnt = cnt; v.ovf = ov; v.unf = un;
        v.vld = vl; v.chk = ck; v.data = d;
        vq.push_back(v);
    endfunction

    task automatic step(input logic we, input logic [DW-1:0] wd,
                        input logic re, input logic cl);
        wren = we; wrdata = wd; rden = re; clr = cl;
        @(posedge clk);
        #1;
        wren = 1'b0; rden = 1'b0; clr = 1'b0; wrdata = '0;
    endtask

    initial begin
        rst = 1'b1; wren = 1'b0; rden = 1'b0; clr = 1'b0; wrdata = '0;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_count", 128'(count), 128'(0));
        cmp("rst_empty", 128'(empty), 128'(1));
        cmp("rst_aempty", 128'(aempty), 128'(1));
        cmp("rst_full", 128'(full), 128'(0));
        cmp("rst_afull", 128'(afull), 128'(0));
        cmp("rst_rddata", rddata, 128'(0));
        cmp("rst_valid", 128'(rd_valid), 128'(0));
        cmp("rst_ovf", 128'(ovf), 128'(0));
        cmp("rst_unf", 128'(unf), 128'(0));
        cmp("rst_f_valid", 128'(f_rd_valid), 128'(0));
        cmp("rst_f_rddata", f_rddata, 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // fill 1..16, overflow, clear, full read+write, clear vs set
        for (int k = 0; k < 16; k++)
            add(1'b1, 128'(k + 1), 1'b0, 1'b0, k + 1,
                1'b0, 1'b0, 1'b0, 1'b0, '0);
        add(1'b1, 128'h99, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        add(1'b0, '0, 1'b0, 1'b1, 16, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        add(1'b1, 128'hAA, 1'b1, 1'b0, 16, 1'b0, 1'b0, 1'b1, 1'b1, 128'h1);
        add(1'b1, 128'h77, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b1, 128'h1);
        add(1'b0, '0, 1'b0, 1'b1, 16, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        // drain: 2..16 then 0xAA
        for (int j = 0; j < 16; j++)
            add(1'b0, '0, 1'b1, 1'b0, 15 - j, 1'b0, 1'b0, 1'b1, 1'b1,
                (j < 15) ? 128'(j + 2) : 128'hAA);
        // underflow holds last data, then empty read+write
        add(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 128'hAA);
        add(1'b0, '0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        add(1'b1, 128'hBB, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b1, 128'hAA);
        add(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 128'hBB);
        add(1'b0, '0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        // wrap-around at a steady level of 8
        for (int k = 0; k < 8; k++)
            add(1'b1, 128'(256 + k), 1'b0, 1'b0, k + 1,
                1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int n = 0; n < 40; n++)
            add(1'b1, 128'(264 + n), 1'b1, 1'b0, 8,
                1'b0, 1'b0, 1'b1, 1'b1, 128'(256 + n));
        for (int k = 0; k < 8; k++)
            add(1'b0, '0, 1'b1, 1'b0, 7 - k,
                1'b0, 1'b0, 1'b1, 1'b1, 128'(296 + k));

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].we, vq[i].wd, vq[i].re, vq[i].cl);
            cmp($sformatf("v%0d_count", i), 128'(count), 128'(vq[i].cnt));
            cmp($sformatf("v%0d_empty", i), 128'(empty),
                128'(vq[i].cnt == 0));
            cmp($sformatf("v%0d_full", i), 128'(full),
                128'(vq[i].cnt == 16));
            cmp($sformatf("v%0d_afull", i), 128'(afull),
                128'(vq[i].cnt >= 14));
            cmp($sformatf("v%0d_aempty", i), 128'(aempty),
                128'(vq[i].cnt <= 2));
            cmp($sformatf("v%0d_ovf", i), 128'(ovf), 128'(vq[i].ovf));
            cmp($sformatf("v%0d_unf", i), 128'(unf), 128'(vq[i].unf));
            cmp($sformatf("v%0d_valid", i), 128'(rd_valid),
                128'(vq[i].vld));
            if (vq[i].chk)
                cmp($sformatf("v%0d_data", i), rddata, vq[i].data);
        end

        // asynchronous reset with 5 entries stored
        for (int k = 0; k < 5; k++)
            step(1'b1, 128'(k + 16), 1'b0, 1'b0);
        cmp("pre_rst_count", 128'(count), 128'(5));
        #2 rst = 1'b1;
        #1;
        cmp("async_rst_count", 128'(count), 128'(0));
        cmp("async_rst_empty", 128'(empty), 128'(1));
        cmp("async_rst_f_valid", 128'(f_rd_valid), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // FWFT instance: word visible without a read request
        step(1'b1, 128'h55, 1'b0, 1'b0);
        cmp("fwft_data", f_rddata, 128'h55);
        cmp("fwft_valid", 128'(f_rd_valid), 128'(1));
        step(1'b0, '0, 1'b0, 1'b0);
        cmp("fwft_hold", f_rddata, 128'h55);
        step(1'b0, '0, 1'b1, 1'b0);
        cmp("fwft_pop_empty", 128'(f_empty), 128'(1));
        cmp("fwft_pop_data", f_rddata, 128'(0));
        cmp("fwft_pop_valid", 128'(f_rd_valid), 128'(0));
        step(1'b1, 128'h66, 1'b0, 1'b0);
        step(1'b1, 128'h77, 1'b0, 1'b0);
        cmp("fwft_head", f_rddata, 128'h66);
        step(1'b0, '0, 1'b1, 1'b0);
        cmp("fwft_next", f_rddata, 128'h77);
        cmp("fwft_count", 128'(f_count), 128'(1));
        cmp("fwft_std_count", 128'(count), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's 128-bit FIFO. Width and depth are generic.
- Adds programmable almost-full/almost-empty thresholds, a fill-level output, and sticky overflow/underflow error flags with clear.
- Adds a selectable read mode: standard (registered, 1-cycle read latency) or first-word-fall-through (FWFT).
- Sits between a producer and a consumer in one clock domain; it is the DUT behind the existing driver/monitor interface signal set.

Parameters:
- DATA_W, 128, width of i_wrdata/o_rddata.
- DEPTH, 16, number of entries; power of two, >= 4.
- ALM_FULL_TH, 14, o_alm_full asserted when count >= ALM_FULL_TH; legal range 1..DEPTH.
- ALM_EMPTY_TH, 2, o_alm_empty asserted when count <= ALM_EMPTY_TH; legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = standard, 1 = first-word-fall-through.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_wren  input  1  write request.
- i_wrdata  input  DATA_W  write data, sampled when a write is accepted.
- i_rden  input  1  read request (standard mode) or pop (FWFT mode).
- i_clr_err  input  1  synchronous clear of o_overflow and o_underflow.
- o_rddata  output  DATA_W  read data.
- o_rd_valid  output  1  o_rddata holds valid data.
- o_full  output  1  count == DEPTH.
- o_empty  output  1  count == 0.
- o_alm_full  output  1  count >= ALM_FULL_TH.
- o_alm_empty  output  1  count <= ALM_EMPTY_TH.
- o_count  output  $clog2(DEPTH)+1  current fill level, 0..DEPTH.
- o_overflow  output  1  sticky: a write was attempted while full and not accepted.
- o_underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high.
  - While rst is high: count = 0, both pointers = 0, o_empty = 1, o_alm_empty = 1, o_full = 0, o_alm_full = 0, o_rddata = 0, o_rd_valid = 0, o_overflow = 0, o_underflow = 0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored data immediately.
- Accept rules, evaluated on the state at the clock edge:
  - rd_ok = i_rden && !o_empty.
  - wr_ok = i_wren && (!o_full || rd_ok).
  - When full, a simultaneous read and write are both accepted; count is unchanged.
  - When empty, a simultaneous read and write: the write is accepted, the read is rejected and sets o_underflow; count becomes 1.
- Pointers: write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count increments on wr_ok only, decrements on rd_ok only, and is unchanged when both or neither occur.
- Flags: all five status outputs derive from the registered count only. They are updated in the cycle after the accepting edge and never glitch within a cycle.
- Standard mode (FWFT = 0):
  - On rd_ok, o_rddata <= mem[rd_ptr] and o_rd_valid <= 1 at the next edge (1-cycle latency).
  - Otherwise o_rd_valid <= 0 and o_rddata holds its last value.
- FWFT mode (FWFT = 1):
  - o_rd_valid = !o_empty.
  - o_rddata = mem[rd_ptr] when not empty, else 0.
  - i_rden acknowledges (pops) the current word; the next word is visible in the following cycle.
  - A word written into an empty FIFO is visible one cycle after the write edge.
- Errors:
  - o_overflow sets on i_wren && !wr_ok.
  - o_underflow sets on i_rden && o_empty.
  - i_clr_err clears both. If a set and a clear coincide in the same cycle, set wins.
  - Errors never change FIFO state.
- Ordering: strict first-in first-out, with no data loss or duplication across pointer wrap.

Test Plan:
- Reset then idle (DEPTH = 16): o_empty = 1, o_alm_empty = 1, o_count = 0, o_rddata = 0, o_rd_valid = 0; rst pulsed while 5 entries are stored -> o_count = 0 and o_empty = 1 in the same cycle.
- Fill and drain: write 0x1..0x10 (16 words) -> o_full = 1 after the 16th write, o_alm_full = 1 from count 14, o_count = 16.
  - Standard mode: reading 16 words returns 0x1..0x10 in order, each with o_rd_valid one cycle after i_rden; o_alm_empty = 1 at count 2.
- Overflow/underflow: a 17th write while full -> o_overflow = 1, o_count stays 16, data unchanged; read while empty -> o_underflow = 1; i_clr_err -> both 0; a clear coinciding with a new overflow -> o_overflow stays 1.
- Simultaneous read/write:
  - Full, write 0xAA plus read -> o_count stays 16 and 0xAA is read last.
  - Empty, write 0xBB plus read -> o_underflow = 1, o_count = 1.
- Wrap-around: 40 cycles of continuous write and read at count ~8 with incrementing data -> output sequence is contiguous, o_count is constant, and neither o_full nor o_empty asserts.
- FWFT = 1: write 0x55 to an empty FIFO -> o_rddata = 0x55 and o_rd_valid = 1 on the next cycle with no i_rden; pop -> o_empty = 1 and o_rddata = 0.
